// File: rtl/washer_timer.sv
// washer_timer: per-phase countdown that feeds the Tf/Tw/Tr/Td/Ts done levels back to the washer FSM.
// Defining WASHER_TIMER_STATUS_EN adds the status_phase/status_remain front-panel ports.
module washer_timer #(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = 8,
  parameter int FILL_T   = 6,
  parameter int WASH_T   = 10,
  parameter int RINSE_T  = 8,
  parameter int DRAIN_T  = 4,
  parameter int SPIN_T   = 12
) (
  input  logic clk,
  input  logic reset,
  input  logic Water,
  input  logic Agitator,
  input  logic Pump,
  input  logic Motor,
  input  logic R,
  input  logic hold,
  output logic Tf,
  output logic Tw,
  output logic Tr,
  output logic Td,
  output logic Ts
`ifdef WASHER_TIMER_STATUS_EN
  ,
  output logic [2:0]       status_phase,
  output logic [CNT_W-1:0] status_remain
`endif
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    RINSE = 3'd3,
    DRAIN = 3'd4,
    SPIN  = 3'd5
  } phase_t;

  if (TICK_DIV < 1) begin : g_tick_check
    $error("washer_timer: TICK_DIV must be at least 1");
  end
  if ((longint'(FILL_T) >= (longint'(1) << CNT_W)) || (longint'(WASH_T) >= (longint'(1) << CNT_W)) ||
      (longint'(RINSE_T) >= (longint'(1) << CNT_W)) || (longint'(DRAIN_T) >= (longint'(1) << CNT_W)) ||
      (longint'(SPIN_T) >= (longint'(1) << CNT_W))) begin : g_dur_check
    $error("washer_timer: a phase duration does not fit in CNT_W bits");
  end

  phase_t            r_phase;
  logic [CNT_W-1:0]  r_cnt;
  logic [PRE_W-1:0]  r_pre;
  logic [4:0]        r_done;
  phase_t            w_decode;
  logic [CNT_W-1:0]  w_load;

  function automatic logic [CNT_W-1:0] phase_duration(input phase_t ph);
    case (ph)
      FILL:    phase_duration = CNT_W'(FILL_T);
      WASH:    phase_duration = CNT_W'(WASH_T);
      RINSE:   phase_duration = CNT_W'(RINSE_T);
      DRAIN:   phase_duration = CNT_W'(DRAIN_T);
      SPIN:    phase_duration = CNT_W'(SPIN_T);
      default: phase_duration = '0;
    endcase
  endfunction

  // Done bit order is {Ts, Td, Tr, Tw, Tf}; IDLE owns no done level.
  function automatic logic [4:0] done_mask(input phase_t ph);
    case (ph)
      FILL:    done_mask = 5'b00001;
      WASH:    done_mask = 5'b00010;
      RINSE:   done_mask = 5'b00100;
      DRAIN:   done_mask = 5'b01000;
      SPIN:    done_mask = 5'b10000;
      default: done_mask = 5'b00000;
    endcase
  endfunction

  // Phase decode from the FSM actuator outputs, first match wins.
  always_comb begin
    w_decode = IDLE;
    if (Water) begin
      w_decode = FILL;
    end else if (Agitator) begin
      w_decode = R ? RINSE : WASH;
    end else if (Pump) begin
      w_decode = Motor ? SPIN : DRAIN;
    end else begin
      w_decode = IDLE;
    end
  end

  assign w_load = phase_duration(w_decode);

  // Phase tracking, prescaled countdown and done levels; a phase change overrides hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= IDLE;
      r_cnt   <= '0;
      r_pre   <= '0;
      r_done  <= 5'b00000;
    end else if (w_decode != r_phase) begin
      r_phase <= w_decode;
      r_cnt   <= w_load;
      r_pre   <= '0;
      r_done  <= 5'b00000;
    end else if (hold) begin
      r_cnt   <= r_cnt;
      r_pre   <= r_pre;
      r_done  <= r_done;
    end else if ((r_cnt == '0) && (r_phase != IDLE)) begin
      r_done  <= done_mask(r_phase);
    end else if (r_pre == PRE_MAX) begin
      r_pre   <= '0;
      r_cnt   <= (r_cnt == '0) ? r_cnt : (r_cnt - CNT_W'(1));
    end else begin
      r_pre   <= r_pre + PRE_W'(1);
    end
  end

  assign Tf = r_done[0];
  assign Tw = r_done[1];
  assign Tr = r_done[2];
  assign Td = r_done[3];
  assign Ts = r_done[4];

`ifdef WASHER_TIMER_STATUS_EN
  assign status_phase  = r_phase;
  assign status_remain = r_cnt;
`endif

endmodule

// File: tb/tb_washer_timer.sv
// Self-checking bench for washer_timer: directed scenarios plus randomized FSM patterns against a cycle-count model.
module tb_washer_timer;

  localparam int TD = 2;
  localparam int CW = 8;
  localparam int FT = 3;
  localparam int WT = 5;
  localparam int RT = 4;
  localparam int DT = 0;
  localparam int ST = 7;

  localparam logic [4:0] P_IDLE  = 5'b00000;
  localparam logic [4:0] P_FILL  = 5'b10000;
  localparam logic [4:0] P_WASH  = 5'b01000;
  localparam logic [4:0] P_RINSE = 5'b01001;
  localparam logic [4:0] P_DRAIN = 5'b00100;
  localparam logic [4:0] P_SPIN  = 5'b00110;

  logic clk, reset, Water, Agitator, Pump, Motor, R, hold;
  logic Tf, Tw, Tr, Td, Ts;
  logic [4:0] dn;
`ifdef WASHER_TIMER_STATUS_EN
  logic [2:0]    status_phase;
  logic [CW-1:0] status_remain;
`endif

  int checks;
  int errors;

  // Reference model: phase id, clk edges still to count, done flag.
  int m_phase;
  int m_left;
  bit m_done;

  washer_timer #(
    .TICK_DIV(TD), .CNT_W(CW), .FILL_T(FT), .WASH_T(WT),
    .RINSE_T(RT), .DRAIN_T(DT), .SPIN_T(ST)
  ) dut (
    .clk(clk), .reset(reset), .Water(Water), .Agitator(Agitator), .Pump(Pump),
    .Motor(Motor), .R(R), .hold(hold),
    .Tf(Tf), .Tw(Tw), .Tr(Tr), .Td(Td), .Ts(Ts)
`ifdef WASHER_TIMER_STATUS_EN
    , .status_phase(status_phase), .status_remain(status_remain)
`endif
  );

  assign dn = {Ts, Td, Tr, Tw, Tf};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_phase(input logic [4:0] v);
    if (v[4]) return 1;
    if (v[3]) return v[0] ? 3 : 2;
    if (v[2]) return v[1] ? 5 : 4;
    return 0;
  endfunction

  function automatic int ref_dur(input int ph);
    case (ph)
      1: return FT;
      2: return WT;
      3: return RT;
      4: return DT;
      5: return ST;
      default: return 0;
    endcase
  endfunction

  function automatic logic [4:0] exp_done();
    logic [4:0] e;
    e = 5'b00000;
    if (m_done && m_phase > 0) e[m_phase-1] = 1'b1;
    return e;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_left  = 0;
    m_done  = 1'b0;
  endtask

  task automatic model_edge();
    int nph;
    if (reset) return;
    nph = ref_phase({Water, Agitator, Pump, Motor, R});
    if (nph != m_phase) begin
      m_phase = nph;
      m_left  = ref_dur(nph) * TD;
      m_done  = 1'b0;
    end else if (hold) begin
      m_left = m_left;
    end else if (m_left == 0) begin
      if (m_phase != 0) m_done = 1'b1;
    end else begin
      m_left = m_left - 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_in(input logic [4:0] v, input logic h);
    {Water, Agitator, Pump, Motor, R} = v;
    hold = h;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_in(P_IDLE, 1'b0);
    model_reset();
    #3;
    checks++;
    if (dn !== 5'b00000) begin errors++; $display("FAIL reset_early dn=%b want 00000", dn); end
    #97;
    checks++;
    if (dn !== 5'b00000) begin errors++; $display("FAIL reset_held dn=%b want 00000", dn); end
`ifdef WASHER_TIMER_STATUS_EN
    checks++;
    if (status_phase !== 3'd0 || status_remain !== '0) begin
      errors++; $display("FAIL reset_status phase=%0d remain=%0d want 0 0", status_phase, status_remain);
    end
`endif
    reset = 1'b0;
    tick();
    checks++;
    if (dn !== 5'b00000) begin errors++; $display("FAIL reset_release dn=%b want 00000", dn); end
  endtask

  task automatic test_fill();
    int n;
    bit bad;
    set_in(P_FILL, 1'b0);
    tick();
    n = 0;
    do begin tick(); n++; end while (!Tf && n < 200);
    checks++;
    if (n != FT * TD + 1) begin errors++; $display("FAIL fill_latency got=%0d want=%0d", n, FT * TD + 1); end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); if (dn !== 5'b00001) bad = 1'b1; end
    checks++;
    if (bad) begin errors++; $display("FAIL fill_level dn=%b want 00001", dn); end
    set_in(P_IDLE, 1'b0);
    tick();
    checks++;
    if (Tf !== 1'b0) begin errors++; $display("FAIL fill_clear Tf=%b want 0", Tf); end
  endtask

  task automatic test_hold();
    int n;
    bit bad;
    set_in(P_IDLE, 1'b0);
    tick();
    set_in(P_WASH, 1'b0);
    tick();
    bad = 1'b0;
    tick(); tick();
    if (dn !== 5'b00000) bad = 1'b1;
    hold = 1'b1;
    for (int i = 0; i < 4; i++) begin tick(); if (dn !== 5'b00000) bad = 1'b1; end
    hold = 1'b0;
    n = 6;
    do begin
      tick(); n++;
      if ((dn & 5'b11101) !== 5'b00000) bad = 1'b1;
    end while (!Tw && n < 200);
    checks++;
    if (n != WT * TD + 1 + 4) begin errors++; $display("FAIL hold_latency got=%0d want=%0d", n, WT * TD + 5); end
    checks++;
    if (bad) begin errors++; $display("FAIL hold_others dn=%b want only Tw at end", dn); end
  endtask

  task automatic test_sequence();
    logic [4:0] pats [7];
    logic [4:0] flags [7];
    int n;
    pats  = '{P_FILL, P_WASH, P_DRAIN, P_FILL, P_RINSE, P_DRAIN, P_SPIN};
    flags = '{5'b00001, 5'b00010, 5'b01000, 5'b00001, 5'b00100, 5'b01000, 5'b10000};
    set_in(P_IDLE, 1'b0);
    tick();
    for (int p = 0; p < 7; p++) begin
      set_in(pats[p], 1'b0);
      n = 0;
      do begin tick(); n++; end while (dn === 5'b00000 && n < 200);
      checks++;
      if (dn !== flags[p]) begin errors++; $display("FAIL seq_step%0d dn=%b want %b", p, dn, flags[p]); end
    end
    set_in(P_IDLE, 1'b0);
    tick(); tick();
    checks++;
    if (dn !== 5'b00000) begin errors++; $display("FAIL seq_idle dn=%b want 00000", dn); end
  endtask

  task automatic test_zero_drain();
    set_in(P_IDLE, 1'b0);
    tick();
    set_in(P_DRAIN, 1'b0);
    tick();
    checks++;
    if (Td !== 1'b0) begin errors++; $display("FAIL zero_first Td=%b want 0", Td); end
    tick();
    checks++;
    if (dn !== 5'b01000) begin errors++; $display("FAIL zero_second dn=%b want 01000", dn); end
  endtask

  task automatic test_async_reset();
    int n;
    set_in(P_IDLE, 1'b0);
    tick();
    set_in(P_SPIN, 1'b0);
    n = 0;
    do begin tick(); n++; end while (!Ts && n < 200);
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (Ts !== 1'b0) begin errors++; $display("FAIL areset_done Ts=%b want 0", Ts); end
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) tick();
`ifdef WASHER_TIMER_STATUS_EN
    checks++;
    if (status_remain !== CW'(5)) begin errors++; $display("FAIL areset_cnt5 remain=%0d want 5", status_remain); end
`endif
    #2 reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dn !== 5'b00000) begin errors++; $display("FAIL areset_mid dn=%b want 00000", dn); end
`ifdef WASHER_TIMER_STATUS_EN
    checks++;
    if (status_remain !== '0 || status_phase !== 3'd0) begin
      errors++; $display("FAIL areset_status remain=%0d phase=%0d want 0 0", status_remain, status_phase);
    end
`endif
    reset = 1'b0;
    tick();
`ifdef WASHER_TIMER_STATUS_EN
    checks++;
    if (status_remain !== CW'(ST)) begin errors++; $display("FAIL areset_reload remain=%0d want %0d", status_remain, ST); end
`endif
    n = 0;
    do begin tick(); n++; end while (!Ts && n < 200);
    checks++;
    if (n != ST * TD + 1) begin errors++; $display("FAIL areset_latency got=%0d want=%0d", n, ST * TD + 1); end
  endtask

  task automatic test_phase_over_hold();
    int n;
    bit bad;
    set_in(P_IDLE, 1'b0);
    tick();
    set_in(P_FILL, 1'b0);
    n = 0;
    do begin tick(); n++; end while (!Tf && n < 200);
    set_in(P_WASH, 1'b1);
    tick();
    checks++;
    if (dn !== 5'b00000) begin errors++; $display("FAIL poh_clear dn=%b want 00000", dn); end
`ifdef WASHER_TIMER_STATUS_EN
    checks++;
    if (status_remain !== CW'(WT) || status_phase !== 3'd2) begin
      errors++; $display("FAIL poh_load remain=%0d phase=%0d want %0d 2", status_remain, status_phase, WT);
    end
`endif
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (dn !== 5'b00000) bad = 1'b1; end
    checks++;
    if (bad) begin errors++; $display("FAIL poh_frozen dn=%b want 00000", dn); end
    hold = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!Tw && n < 200);
    checks++;
    if (n != WT * TD + 1) begin errors++; $display("FAIL poh_latency got=%0d want=%0d", n, WT * TD + 1); end
  endtask

  task automatic test_random();
    logic [4:0] e;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 15) == 0) {Water, Agitator, Pump, Motor, R} = 5'($urandom);
      if ($urandom_range(0, 9) == 0) hold = ~hold;
      if (c == 700) begin
        #2 reset = 1'b1;
        model_reset();
        #1 reset = 1'b0;
      end
      tick();
      e = exp_done();
      checks++;
      if (dn !== e) begin errors++; $display("FAIL rand_cycle%0d dn=%b want %b", c, dn, e); end
`ifdef WASHER_TIMER_STATUS_EN
      checks++;
      if (status_phase !== 3'(m_phase)) begin
        errors++; $display("FAIL rand_phase%0d phase=%0d want %0d", c, status_phase, m_phase);
      end
`endif
    end
    hold = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_fill();
    test_hold();
    test_sequence();
    test_zero_drain();
    test_async_reset();
    test_phase_over_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
